// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle for led_pattern_gen.
// The master side supplies run controls, and the slave side returns the LED image and frame pulse.
interface led_pattern_gen_if #(
    parameter int N     = 8,
    parameter int DIV_W = 24
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     led;
    logic             frame;

    modport master (output en, mode, div, input led, frame);
    modport slave  (input en, mode, div, output led, frame);
endinterface

// File: rtl/led_pattern_gen.sv
// N-LED pattern sequencer with a programmable step prescaler.
// Supports four patterns and emits a one-cycle frame pulse on sequence wrap.
module led_pattern_gen #(
    parameter int N     = 8,
    parameter int DIV_W = 24
) (
    input logic              CLK,
    input logic              rs_n,
    led_pattern_gen_if.slave bus
);
    localparam int STEP_W = $clog2(2 * N);

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_DRAIN  = 2'd3;

    localparam logic [N-1:0]      ONES     = '1;
    localparam logic [N-1:0]      LSB      = N'(1);
    localparam logic [N:0]        FILL_ONE = (N + 1)'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [DIV_W-1:0]  PRESC_ONE = DIV_W'(1);

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        mode_q, mode_d;
    logic              frame_q, frame_d;
    logic              tick, mode_chg, at_last;

    function automatic logic [STEP_W-1:0] last_step(input logic [1:0] m);
        case (m)
            MODE_CHASE:  return STEP_W'(N - 1);
            MODE_FILL:   return STEP_W'(2 * N - 1);
            MODE_BOUNCE: return STEP_W'(2 * N - 3);
            default:     return STEP_W'(N);
        endcase
    endfunction

    function automatic logic [N-1:0] pattern(input logic [1:0] m, input logic [STEP_W-1:0] s);
        int         si;
        int         p;
        logic [N:0] fill;
        si   = int'(s);
        fill = '0;
        case (m)
            MODE_CHASE: return LSB << si;
            MODE_FILL: begin
                // One extra bit so the fill at s = N-1 does not overflow before the -1
                if (si < N) begin
                    fill = (FILL_ONE << (si + 1)) - FILL_ONE;
                    return fill[N-1:0];
                end
                return ONES >> (si - N + 1);
            end
            MODE_BOUNCE: begin
                p = (si < N) ? si : (2 * N - 2 - si);
                return LSB << p;
            end
            default: return ONES >> si;
        endcase
    endfunction

    always_comb begin
        mode_chg = (bus.mode != mode_q);
        at_last  = (step_q == last_step(mode_q));
        // The >= lets a lowered div take effect at once, without waiting for a counter wrap
        tick     = bus.en && (presc_q >= bus.div);
        presc_d  = presc_q;
        step_d   = step_q;
        frame_d  = 1'b0;
        mode_d   = bus.mode;
        if (mode_chg) begin
            presc_d = '0;
            step_d  = '0;
        end else if (tick) begin
            presc_d = '0;
            step_d  = at_last ? '0 : step_q + STEP_ONE;
            frame_d = at_last;
        end else if (bus.en) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_ff @(posedge CLK or negedge rs_n) begin
        if (!rs_n) begin
            presc_q <= '0;
            step_q  <= '0;
            mode_q  <= MODE_CHASE;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
        end
    end

    assign bus.led   = pattern(mode_q, step_q);
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed, table-driven bench for led_pattern_gen with N=8.
module tb_led_pattern_gen;
    logic CLK = 1'b0;
    logic rs_n;
    int   tests = 0;
    int   fails = 0;

    led_pattern_gen_if #(.N(8), .DIV_W(24)) bus ();

    led_pattern_gen #(.N(8), .DIV_W(24)) dut (
        .CLK  (CLK),
        .rs_n (rs_n),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [23:0] div;
        logic [7:0]  led;
        logic        frame;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] fd_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

    function automatic void add(input logic e, input logic [1:0] m, input logic [23:0] d,
                                input logic [7:0] l, input logic f);
        vec_t v;
        v.en = e; v.mode = m; v.div = d; v.led = l; v.frame = f;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Called at posedge+1; pulses reset between edges and checks the asynchronous clear.
    task automatic rst_pulse_chk(input string tag);
        #2 rs_n = 1'b0;
        #1;
        chk({tag, " async led"}, bus.led, 32'h01);
        chk({tag, " async frame"}, bus.frame, 32'h0);
        #1 rs_n = 1'b1;
    endtask

    initial begin
        rs_n = 1'b0; bus.en = 1'b0; bus.mode = 2'd0; bus.div = 24'd0;
        #1;
        chk("reset led", bus.led, 32'h01);
        chk("reset frame", bus.frame, 32'h0);
        repeat (2) cyc();
        chk("reset held led", bus.led, 32'h01);
        rs_n = 1'b1;

        // CHASE, div=0
        add(1,0,0,8'h02,0); add(1,0,0,8'h04,0); add(1,0,0,8'h08,0); add(1,0,0,8'h10,0);
        add(1,0,0,8'h20,0); add(1,0,0,8'h40,0); add(1,0,0,8'h80,0); add(1,0,0,8'h01,1);
        add(1,0,0,8'h02,0);
        // BOUNCE, div=0
        add(1,2,0,8'h01,0); add(1,2,0,8'h02,0); add(1,2,0,8'h04,0); add(1,2,0,8'h08,0);
        add(1,2,0,8'h10,0); add(1,2,0,8'h20,0); add(1,2,0,8'h40,0); add(1,2,0,8'h80,0);
        add(1,2,0,8'h40,0); add(1,2,0,8'h20,0); add(1,2,0,8'h10,0); add(1,2,0,8'h08,0);
        add(1,2,0,8'h04,0); add(1,2,0,8'h02,0); add(1,2,0,8'h01,1); add(1,2,0,8'h02,0);
        // DRAIN, div=0
        add(1,3,0,8'hFF,0); add(1,3,0,8'h7F,0); add(1,3,0,8'h3F,0); add(1,3,0,8'h1F,0);
        add(1,3,0,8'h0F,0); add(1,3,0,8'h07,0); add(1,3,0,8'h03,0); add(1,3,0,8'h01,0);
        add(1,3,0,8'h00,0); add(1,3,0,8'hFF,1);
        // FILL_DRAIN, div=1, with a two-cycle freeze mid-step
        add(1,1,1,8'h01,0); add(1,1,1,8'h01,0); add(1,1,1,8'h03,0); add(1,1,1,8'h03,0);
        add(1,1,1,8'h07,0); add(0,1,1,8'h07,0); add(0,1,1,8'h07,0); add(1,1,1,8'h07,0);
        add(1,1,1,8'h0F,0);
        // CHASE up to 0x10, then switch to DRAIN on an edge that also ticks
        add(1,0,0,8'h01,0); add(1,0,0,8'h02,0); add(1,0,0,8'h04,0); add(1,0,0,8'h08,0);
        add(1,0,0,8'h10,0); add(1,3,0,8'hFF,0); add(1,3,0,8'h7F,0); add(1,3,0,8'h3F,0);

        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.mode = vecs[i].mode; bus.div = vecs[i].div;
            cyc();
            chk($sformatf("vec%0d led", i), bus.led, vecs[i].led);
            chk($sformatf("vec%0d frame", i), bus.frame, vecs[i].frame);
        end

        // Full FILL_DRAIN sequence at div=3: every value is held for 4 cycles, with a single wrap pulse.
        bus.en = 1'b1; bus.mode = 2'd1; bus.div = 24'd3;
        for (int k = 0; k < 69; k++) begin
            cyc();
            chk($sformatf("fd k%0d led", k), bus.led, fd_seq[(k / 4) % 16]);
            chk($sformatf("fd k%0d frame", k), bus.frame, (k == 64) ? 32'h1 : 32'h0);
        end

        // Lower div from 100 to 2 while presc=50.
        bus.mode = 2'd0; bus.div = 24'd100;
        rst_pulse_chk("div");
        repeat (50) cyc();
        chk("div slow led", bus.led, 32'h01);
        bus.div = 24'd2;
        cyc();
        chk("div fast first led", bus.led, 32'h02);
        cyc(); cyc();
        chk("div fast hold led", bus.led, 32'h02);
        cyc();
        chk("div fast step2 led", bus.led, 32'h04);
        repeat (3) cyc();
        chk("div fast step3 led", bus.led, 32'h08);

        // Asynchronous reset during FILL_DRAIN step 9, with the mode input left at 1.
        bus.mode = 2'd1; bus.div = 24'd0;
        rst_pulse_chk("fd pre");
        repeat (10) cyc();
        chk("fd step9 led", bus.led, 32'h3F);
        rst_pulse_chk("fd mid");
        cyc();
        chk("fd restart led", bus.led, 32'h01);
        cyc();
        chk("fd restart step1 led", bus.led, 32'h03);

        // Asynchronous reset while frame is high clears it at once.
        bus.mode = 2'd0;
        rst_pulse_chk("frm pre");
        repeat (8) cyc();
        chk("frm wrap frame", bus.frame, 32'h1);
        chk("frm wrap led", bus.led, 32'h01);
        rst_pulse_chk("frm mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
